dram_w2b_fifo_ctrl: RTL and testbench

//  - Controller that runs the 16x32-write / 64x8-read distributed RAM (dRAM) as a word-in, byte-out FIFO.
//  - Accepts 32-bit words on a valid/ready slave port and emits bytes LSB-first on a valid/ready master port.
//  - Generates dRAM waddr/we/di/raddr and owns all pointer, flag and level logic.
//  - Sits between the 32-bit bus side and 8-bit peripherals (UART TX, SPI), one dRAM instance per controller.

---
 rtl/dram_w2b_pkg.sv | 15 +
 rtl/dram_w2b_outreg.sv | 45 ++++
 rtl/dram_w2b_fifo_ctrl.sv | 91 +++++++++
 tb/tb_dram_w2b_fifo_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_w2b_pkg.sv
// Shared sizing for the word-in / byte-out dRAM FIFO controller.
// Pointer widths carry one extra wrap bit above the address bits.
package dram_w2b_pkg;

    localparam int AW_W           = 4;
    localparam int BSEL           = 2;
    localparam int DEPTH_W        = 16;
    localparam int BYTES_PER_WORD = 4;

    localparam int WPTR_W  = AW_W + 1;
    localparam int RADDR_W = AW_W + BSEL;
    localparam int RPTR_W  = RADDR_W + 1;
    localparam int LEVEL_W = AW_W + 1;

endpackage

// File: rtl/dram_w2b_outreg.sv
// One-entry output skid register between the dRAM async read port and m_data.
// Loads when RAM has a byte and the register is empty or draining; clr/rst drop it.
module dram_w2b_outreg (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_vld,
    input  logic [7:0] in_dat,
    input  logic       out_rdy,
    output logic       load,
    output logic       out_vld,
    output logic [7:0] out_dat
);

    logic       vld_q, vld_d;
    logic [7:0] dat_q, dat_d;

    always_comb begin
        load  = in_vld & (~vld_q | out_rdy) & ~clr & ~rst;
        vld_d = vld_q;
        dat_d = dat_q;
        if (clr) begin
            vld_d = 1'b0;
        end else if (load) begin
            vld_d = 1'b1;
            dat_d = in_dat;
        end else if (out_rdy) begin
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign out_vld = vld_q;
    assign out_dat = dat_q;

endmodule

// File: rtl/dram_w2b_fifo_ctrl.sv
// Runs a 16x32-write / 64x8-read dRAM as a word-in, byte-out (LSB first) FIFO.
// Optional output register via DRAM_W2B_FIFO_REGOUT_EN (push->m_valid 2 cycles instead of 1).
module dram_w2b_fifo_ctrl
    import dram_w2b_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [31:0]         s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [7:0]          m_data,
    output logic [LEVEL_W-1:0]  level,
    output logic                full,
    output logic                empty,
    output logic                dram_we,
    output logic [AW_W-1:0]     dram_waddr,
    output logic [31:0]         dram_di,
    output logic [RADDR_W-1:0]  dram_raddr,
    input  logic [7:0]          dram_do
);

    logic [WPTR_W-1:0] wptr_q, wptr_d;
    logic [RPTR_W-1:0] rptr_q, rptr_d;
    logic [WPTR_W-1:0] rword;
    logic              ram_empty;
    logic              push;
    logic              rd_adv;

    // Word-granular view of the read pointer; a slot frees only when byte 3 is consumed.
    assign rword     = rptr_q[RPTR_W-1:BSEL];
    assign ram_empty = (rword == wptr_q);
    assign full      = (wptr_q[AW_W-1:0] == rword[AW_W-1:0]) & (wptr_q[AW_W] != rword[AW_W]);
    assign s_ready   = ~full;
    assign push      = s_valid & s_ready & ~flush & ~rst;
    assign level     = wptr_q - rword;

    assign dram_we    = push;
    assign dram_waddr = wptr_q[AW_W-1:0];
    assign dram_di    = s_data;
    assign dram_raddr = rptr_q[RADDR_W-1:0];

`ifdef DRAM_W2B_FIFO_REGOUT_EN
    logic reg_vld;

    dram_w2b_outreg u_outreg (
        .clk     (clk),
        .rst     (rst),
        .clr     (flush),
        .in_vld  (~ram_empty),
        .in_dat  (dram_do),
        .out_rdy (m_ready),
        .load    (rd_adv),
        .out_vld (reg_vld),
        .out_dat (m_data)
    );

    assign m_valid = reg_vld;
    assign empty   = ~reg_vld & ram_empty;
`else
    assign m_valid = ~ram_empty;
    assign m_data  = dram_do;
    assign empty   = ram_empty;
    assign rd_adv  = m_valid & m_ready;
`endif

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push)   wptr_d = wptr_q + 1'b1;
            if (rd_adv) rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

endmodule

// File: tb/tb_dram_w2b_fifo_ctrl.sv
// Scoreboard bench for dram_w2b_fifo_ctrl with a behavioural 16x32 / 64x8 dRAM model.
module tb_dram_w2b_fifo_ctrl;

`ifdef DRAM_W2B_FIFO_REGOUT_EN
    localparam int LAT          = 2;
    localparam int POPS_TO_FREE = 3;
`else
    localparam int LAT          = 1;
    localparam int POPS_TO_FREE = 4;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, s_valid, m_ready;
    logic [31:0] s_data;
    logic        s_ready, m_valid, full, empty, dram_we;
    logic [7:0]  m_data, dram_do;
    logic [4:0]  level;
    logic [3:0]  dram_waddr;
    logic [31:0] dram_di;
    logic [5:0]  dram_raddr;

    always #5 clk = ~clk;

    dram_w2b_fifo_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .level(level), .full(full), .empty(empty),
        .dram_we(dram_we), .dram_waddr(dram_waddr), .dram_di(dram_di),
        .dram_raddr(dram_raddr), .dram_do(dram_do)
    );

    logic [31:0] mem [16];
    logic [31:0] rd_word;
    initial for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    always @(posedge clk) if (dram_we) mem[dram_waddr] <= dram_di;
    assign rd_word = mem[dram_raddr[5:2]];
    assign dram_do = rd_word[dram_raddr[1:0]*8 +: 8];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [7:0] sb [$];
    logic [7:0] exp_b;

    logic       obs_sready, obs_mvalid, obs_we, obs_full, obs_empty, popd, accd;
    logic [7:0] obs_mdata;
    logic [4:0] obs_level;
    logic [3:0] obs_waddr;
    logic [31:0] obs_di;

    // One clock: drive at negedge, observe 1ns later, commit at posedge.
    task automatic step(input logic sv, input logic [31:0] sd, input logic mr, input logic fl);
        @(negedge clk);
        s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
        #1;
        obs_sready = s_ready; obs_mvalid = m_valid; obs_mdata = m_data;
        obs_we = dram_we; obs_full = full; obs_empty = empty; obs_level = level;
        obs_waddr = dram_waddr; obs_di = dram_di;
        popd = m_valid && mr && !fl;
        accd = sv && s_ready && !fl;
        if (accd) for (int b = 0; b < 4; b++) sb.push_back(sd[8*b +: 8]);
        @(posedge clk);
        cyc++;
        if (fl) sb.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0; #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL reset_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (dram_we !== 1'b0) $display("FAIL reset_dram_we: got %b want 0", dram_we); else n_pass++;
        n_checks++; if (dram_raddr !== 6'd0) $display("FAIL reset_raddr: got %0d want 0", dram_raddr); else n_pass++;
    endtask

    task automatic test_single_word();
        int p, first, last, got;
        step(1'b1, 32'h44332211, 1'b1, 1'b0);
        p = cyc; first = -1; last = -1; got = 0;
        n_checks++; if (obs_we !== 1'b1) $display("FAIL single_we: got %b want 1", obs_we); else n_pass++;
        n_checks++; if (obs_waddr !== 4'd0) $display("FAIL single_waddr: got %0d want 0", obs_waddr); else n_pass++;
        n_checks++; if (obs_di !== 32'h44332211) $display("FAIL single_di: got %h want 44332211", obs_di); else n_pass++;
        for (int i = 0; i < 20 && got < 4; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (popd) begin
                if (got == 0) first = cyc;
                last = cyc; got++;
                exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_checks++; if (obs_mdata !== exp_b) $display("FAIL single_byte: got %h want %h", obs_mdata, exp_b); else n_pass++;
            end
        end
        n_checks++; if (got !== 4) $display("FAIL single_count: got %0d want 4", got); else n_pass++;
        n_checks++; if (first - p !== LAT) $display("FAIL single_latency: got %0d want %0d", first - p, LAT); else n_pass++;
        n_checks++; if (last - first !== 3) $display("FAIL single_consecutive: got %0d want 3", last - first); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (obs_empty !== 1'b1) $display("FAIL single_empty: got %b want 1", obs_empty); else n_pass++;
        n_checks++; if (obs_level !== 5'd0) $display("FAIL single_level: got %0d want 0", obs_level); else n_pass++;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, $urandom, 1'b0, 1'b0);
            n_checks++; if (accd !== 1'b1) $display("FAIL fill_accept: got %b want 1 at word %0d", accd, i); else n_pass++;
        end
        step(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
        n_checks++; if (obs_full !== 1'b1) $display("FAIL fill_full: got %b want 1", obs_full); else n_pass++;
        n_checks++; if (obs_sready !== 1'b0) $display("FAIL fill_s_ready: got %b want 0", obs_sready); else n_pass++;
        n_checks++; if (obs_level !== 5'd16) $display("FAIL fill_level: got %0d want 16", obs_level); else n_pass++;
        n_checks++; if (obs_we !== 1'b0) $display("FAIL fill_extra_we: got %b want 0", obs_we); else n_pass++;
    endtask

    task automatic test_full_pop();
        for (int k = 0; k < POPS_TO_FREE; k++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++; if (obs_sready !== 1'b0) $display("FAIL fullpop_s_ready: got %b want 0 at pop %0d", obs_sready, k); else n_pass++;
            n_checks++; if (obs_mvalid !== 1'b1) $display("FAIL fullpop_m_valid: got %b want 1 at pop %0d", obs_mvalid, k); else n_pass++;
            if (popd) begin
                exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_checks++; if (obs_mdata !== exp_b) $display("FAIL fullpop_byte: got %h want %h", obs_mdata, exp_b); else n_pass++;
            end
        end
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (obs_sready !== 1'b1) $display("FAIL fullpop_s_ready_next: got %b want 1", obs_sready); else n_pass++;
        n_checks++; if (obs_level !== 5'd15) $display("FAIL fullpop_level: got %0d want 15", obs_level); else n_pass++;
    endtask

    task automatic test_stream();
        int want, got, sent;
        logic sv;
        want = sb.size() + 160; got = 0; sent = 0;
        for (int c = 0; c < 3000 && got < want; c++) begin
            sv = (sent < 40) && ($urandom_range(0, 3) != 0);
            step(sv, $urandom, $urandom_range(0, 2) != 0, 1'b0);
            if (accd) sent++;
            if (popd) begin
                got++;
                exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_checks++; if (obs_mdata !== exp_b) $display("FAIL stream_byte: got %h want %h at byte %0d", obs_mdata, exp_b, got); else n_pass++;
            end
        end
        n_checks++; if (sent !== 40) $display("FAIL stream_sent: got %0d want 40", sent); else n_pass++;
        n_checks++; if (got !== want) $display("FAIL stream_count: got %0d want %0d", got, want); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (obs_empty !== 1'b1) $display("FAIL stream_empty: got %b want 1", obs_empty); else n_pass++;
        n_checks++; if (obs_level !== 5'd0) $display("FAIL stream_level: got %0d want 0", obs_level); else n_pass++;
    endtask

    task automatic test_flush();
        logic [3:0] fa;
        for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            n_checks++; if (popd !== 1'b1) $display("FAIL flush_pre_pop: got %b want 1", popd); else n_pass++;
            if (popd) begin
                exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_checks++; if (obs_mdata !== exp_b) $display("FAIL flush_pre_byte: got %h want %h", obs_mdata, exp_b); else n_pass++;
            end
        end
        step(1'b1, 32'hCAFEF00D, 1'b0, 1'b1);
        fa = obs_waddr;
        n_checks++; if (obs_we !== 1'b0) $display("FAIL flush_we: got %b want 0", obs_we); else n_pass++;
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (mem[fa] === 32'hCAFEF00D) $display("FAIL flush_no_write: got %h want not cafef00d", mem[fa]); else n_pass++;
        n_checks++; if (obs_empty !== 1'b1) $display("FAIL flush_empty: got %b want 1", obs_empty); else n_pass++;
        n_checks++; if (obs_level !== 5'd0) $display("FAIL flush_level: got %0d want 0", obs_level); else n_pass++;
        n_checks++; if (obs_mvalid !== 1'b0) $display("FAIL flush_m_valid: got %b want 0", obs_mvalid); else n_pass++;
    endtask

    task automatic test_rst_mid();
        int p, first;
        for (int i = 0; i < 7; i++) step(1'b1, $urandom, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0);
        n_checks++; if (obs_level !== 5'd7) $display("FAIL rstmid_level_before: got %0d want 7", obs_level); else n_pass++;
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0; sb.delete(); #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rstmid_s_ready: got %b want 1", s_ready); else n_pass++;
        n_checks++; if (m_valid !== 1'b0) $display("FAIL rstmid_m_valid: got %b want 0", m_valid); else n_pass++;
        n_checks++; if (empty !== 1'b1) $display("FAIL rstmid_empty: got %b want 1", empty); else n_pass++;
        n_checks++; if (full !== 1'b0) $display("FAIL rstmid_full: got %b want 0", full); else n_pass++;
        n_checks++; if (level !== 5'd0) $display("FAIL rstmid_level: got %0d want 0", level); else n_pass++;
        n_checks++; if (dram_we !== 1'b0) $display("FAIL rstmid_dram_we: got %b want 0", dram_we); else n_pass++;
        n_checks++; if (dram_raddr !== 6'd0) $display("FAIL rstmid_raddr: got %0d want 0", dram_raddr); else n_pass++;
        step(1'b1, 32'h88776655, 1'b1, 1'b0);
        p = cyc; first = -1;
        for (int i = 0; i < 10 && first < 0; i++) begin
            step(1'b0, 32'h0, 1'b1, 1'b0);
            if (popd) begin
                first = cyc;
                exp_b = (sb.size() > 0) ? sb.pop_front() : 8'hxx;
                n_checks++; if (obs_mdata !== exp_b) $display("FAIL rstmid_byte: got %h want %h", obs_mdata, exp_b); else n_pass++;
            end
        end
        n_checks++; if (first - p !== LAT) $display("FAIL rstmid_latency: got %0d want %0d", first - p, LAT); else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_word();
        test_fill();
        test_full_pop();
        test_stream();
        test_flush();
        test_rst_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
